// File: rtl/serial_tx_pkg.sv
// Shared types for the serial frame transmitter: parity modes, FSM states
// and a helper giving the number of line bits in one frame.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int frame_bits(input int dataW, input bit parity, input int stopBits);
        return 1 + dataW + int'(parity) + stopBits;
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Small synchronous show-ahead FIFO feeding the transmitter; reports its
// occupancy so the transmitter can derive tx_ready from it.
module serial_tx_fifo
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              doPush;
    logic              doPop;

    assign empty  = (count == '0);
    assign doPush = push && (count < CNT_W'(DEPTH));
    assign doPop  = pop && !empty;
    assign rdData = mem[rdPtr];

    // Storage is left unreset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Asynchronous serial frame transmitter: start, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits. Define SERIAL_TX_FIFO_EN for the input FIFO.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 7,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [1:0]                    parity_mode,
    output logic                          SendBit,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : gBadDataW
            $error("serial_frame_tx: DATA_W must be in 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
            $error("serial_frame_tx: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : gBadClksPerBit
            $error("serial_frame_tx: CLKS_PER_BIT must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadFifoDepth
            $error("serial_frame_tx: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    tx_state_t         state;
    logic [DIV_W-1:0]  divCnt;
    logic [IDX_W-1:0]  bitIdx;
    logic              stopCnt;
    logic [DATA_W-1:0] shiftReg;
    logic              parEn;
    logic              parBit;

    logic              startFrame;
    logic [DATA_W-1:0] startData;
    logic              bitEnd;
    logic              lastStop;
    logic              finalStop;
    logic              doneNext;
    parity_mode_t      mode;
    logic              startParEn;
    logic              startParBit;

    assign bitEnd    = (divCnt == DIV_W'(CLKS_PER_BIT - 1));
    assign lastStop  = (stopCnt == 1'(STOP_BITS - 1));
    assign finalStop = (state == ST_STOP) && lastStop && bitEnd;
    // frame_done is registered, so it is armed one cycle before the last stop clock.
    assign doneNext  = (state == ST_STOP) && lastStop && (divCnt == DIV_W'(CLKS_PER_BIT - 2));

    assign mode        = parity_mode_t'(parity_mode);
    assign startParEn  = (mode == PAR_EVEN) || (mode == PAR_ODD);
    assign startParBit = (mode == PAR_ODD) ? ~(^startData) : (^startData);

`ifdef SERIAL_TX_FIFO_EN
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [LVL_W-1:0]  fifoLevel;
    logic              fifoEmpty;
    logic              fifoPush;

    assign tx_ready   = (fifoLevel < LVL_W'(FIFO_DEPTH));
    assign fifoPush   = tx_valid && tx_ready;
    assign startFrame = !fifoEmpty && ((state == ST_IDLE) || finalStop);
    assign fifo_level = fifoLevel;

    serial_tx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .Reset  (Reset),
        .wrData (tx_data),
        .push   (fifoPush),
        .pop    (startFrame),
        .rdData (startData),
        .count  (fifoLevel),
        .empty  (fifoEmpty)
    );
`else
    assign tx_ready   = (state == ST_IDLE);
    assign startFrame = tx_valid && (state == ST_IDLE);
    assign startData  = tx_data;
    assign fifo_level = '0;
`endif

    // Frame sequencer: a new frame start always wins, including over the final
    // stop cycle, which is what lets FIFO-fed frames run back to back.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            SendBit    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            divCnt     <= '0;
            bitIdx     <= '0;
            stopCnt    <= 1'b0;
            shiftReg   <= '0;
            parEn      <= 1'b0;
            parBit     <= 1'b0;
        end else begin
            frame_done <= doneNext;
            if (startFrame) begin
                state    <= ST_START;
                SendBit  <= 1'b0;
                busy     <= 1'b1;
                divCnt   <= '0;
                bitIdx   <= '0;
                stopCnt  <= 1'b0;
                shiftReg <= startData;
                parEn    <= startParEn;
                parBit   <= startParBit;
            end else begin
                case (state)
                    ST_IDLE: begin
                        SendBit <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: begin
                        if (!bitEnd) begin
                            divCnt <= divCnt + DIV_W'(1);
                        end else begin
                            divCnt <= '0;
                            case (state)
                                ST_START: begin
                                    state    <= ST_DATA;
                                    bitIdx   <= '0;
                                    SendBit  <= shiftReg[0];
                                    shiftReg <= shiftReg >> 1;
                                end
                                ST_DATA: begin
                                    if (bitIdx == IDX_W'(DATA_W - 1)) begin
                                        stopCnt <= 1'b0;
                                        if (parEn) begin
                                            state   <= ST_PARITY;
                                            SendBit <= parBit;
                                        end else begin
                                            state   <= ST_STOP;
                                            SendBit <= 1'b1;
                                        end
                                    end else begin
                                        bitIdx   <= bitIdx + IDX_W'(1);
                                        SendBit  <= shiftReg[0];
                                        shiftReg <= shiftReg >> 1;
                                    end
                                end
                                ST_PARITY: begin
                                    state   <= ST_STOP;
                                    SendBit <= 1'b1;
                                    stopCnt <= 1'b0;
                                end
                                ST_STOP: begin
                                    if (lastStop) begin
                                        state   <= ST_IDLE;
                                        busy    <= 1'b0;
                                        SendBit <= 1'b1;
                                    end else begin
                                        stopCnt <= 1'b1;
                                    end
                                end
                                default: begin
                                    state   <= ST_IDLE;
                                    busy    <= 1'b0;
                                    SendBit <= 1'b1;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule
